// File: rtl/am_pkg.sv
// Shared constants and the baseband-select encoding for the AM modulator.
package am_pkg;

    localparam logic [7:0] MID = 8'h80;
    localparam int ENV_ONE = 256;
    localparam int DEPTH_SHIFT = 7;
    localparam int OUT_SHIFT = 9;

    typedef enum logic [1:0] {
        SEL_J1   = 2'd0,
        SEL_J2   = 2'd1,
        SEL_AVG  = 2'd2,
        SEL_NONE = 2'd3
    } sel_e;

endpackage

// File: rtl/am_sgn_mult.sv
// Registered signed x unsigned multiplier with load enable; holds its product when disabled.
module am_sgn_mult #(
    parameter int AW = 8,
    parameter int BW = 8,
    parameter int PW = AW + BW + 1
) (
    input  logic                 i_clk,
    input  logic                 i_srst,
    input  logic                 i_en,
    input  logic signed [AW-1:0] i_a,
    input  logic        [BW-1:0] i_b,
    output logic signed [PW-1:0] o_p
);

    localparam int FULL_W = AW + BW + 1;

    logic signed [BW:0]       w_b_ext;
    logic signed [FULL_W-1:0] w_prod;
    logic signed [PW-1:0]     r_p;

    // Zero-extend the unsigned operand so a plain signed multiply is exact.
    assign w_b_ext = $signed({1'b0, i_b});
    assign w_prod  = FULL_W'(i_a) * FULL_W'(w_b_ext);

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p <= PW'(w_prod);
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/am_modulator.sv
// Double-sideband AM: envelope 1 + m*b(t) multiplied onto the carrier in a
// 3-stage valid-qualified pipeline.
module am_modulator
    import am_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ENV_W = 9
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    carrier,
    input  logic [DW-1:0]    jidai1,
    input  logic [DW-1:0]    jidai2,
    input  logic [7:0]       depth,
    input  logic [1:0]       sel,
    output logic [DW-1:0]    am_out,
    output logic [ENV_W-1:0] env_out,
    output logic             out_valid
);

    localparam int MB_W = DW + 8 + 1;
    localparam int P_W  = DW + ENV_W + 1;
    localparam logic [DW-1:0] L_MID = DW'(MID) << (DW - 8);

    // ---------------- stage 1: offset-binary to signed, baseband select
    logic [DW-1:0]        w_bb_raw [2];
    logic signed [DW-1:0] w_bb     [2];
    logic signed [DW:0]   w_bb_sum;
    logic signed [DW-1:0] w_c_s;
    logic signed [DW-1:0] w_b_s;
    sel_e                 w_sel;

    assign w_bb_raw[0] = jidai1;
    assign w_bb_raw[1] = jidai2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bb
            assign w_bb[gi] = w_bb_raw[gi] ^ L_MID;
        end
    endgenerate

    assign w_c_s    = carrier ^ L_MID;
    assign w_bb_sum = (DW+1)'(w_bb[0]) + (DW+1)'(w_bb[1]);
    assign w_sel    = sel_e'(sel);

    always_comb begin
        w_b_s = '0;
        case (w_sel)
            SEL_J1:   w_b_s = w_bb[0];
            SEL_J2:   w_b_s = w_bb[1];
            SEL_AVG:  w_b_s = DW'(w_bb_sum >>> 1);
            SEL_NONE: w_b_s = '0;
            default:  w_b_s = '0;
        endcase
    end

    logic                 r_v1;
    logic signed [DW-1:0] r_c1;
    logic signed [DW-1:0] r_b1;
    logic [7:0]           r_depth;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_c1    <= '0;
            r_b1    <= '0;
            r_depth <= '0;
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_c1    <= w_c_s;
                r_b1    <= w_b_s;
                r_depth <= depth;
            end
        end
    end

    // ---------------- stage 2: m*b product, carrier delayed alongside
    logic signed [MB_W-1:0] w_mb;
    logic                   r_v2;
    logic signed [DW-1:0]   r_c2;

    am_sgn_mult #(
        .AW (DW),
        .BW (8),
        .PW (MB_W)
    ) u_mult_mb (
        .i_clk  (clk_in),
        .i_srst (rst),
        .i_en   (r_v1),
        .i_a    (r_b1),
        .i_b    (r_depth),
        .o_p    (w_mb)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_v2 <= 1'b0;
            r_c2 <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_c2 <= r_c1;
            end
        end
    end

    // Envelope lies in [1, 509], so it is carried as an unsigned value.
    logic [ENV_W-1:0] w_env;
    assign w_env = ENV_W'(MB_W'(ENV_ONE) + (w_mb >>> DEPTH_SHIFT));

    // ---------------- stage 3: carrier x envelope, rescale to output width
    logic signed [P_W-1:0] w_p;
    logic [DW-1:0]         w_y;
    logic                  r_ov;
    logic [ENV_W-1:0]      r_env;

    am_sgn_mult #(
        .AW (DW),
        .BW (ENV_W),
        .PW (P_W)
    ) u_mult_out (
        .i_clk  (clk_in),
        .i_srst (rst),
        .i_en   (r_v2),
        .i_a    (r_c2),
        .i_b    (w_env),
        .o_p    (w_p)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_ov  <= 1'b0;
            r_env <= '0;
        end else begin
            r_ov <= r_v2;
            if (r_v2) begin
                r_env <= w_env;
            end
        end
    end

    // Unity envelope lands at half scale, leaving headroom for the peaks.
    assign w_y       = DW'(w_p >>> OUT_SHIFT);
    assign am_out    = w_y ^ L_MID;
    assign env_out   = r_env;
    assign out_valid = r_ov;

endmodule

// File: tb/tb_am_modulator.sv
// Randomised and directed stimulus for am_modulator against an arithmetic reference model.
module tb_am_modulator;

    localparam int DW    = 8;
    localparam int ENV_W = 9;
    localparam int N     = 2700;

    logic             clk_in = 1'b1;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    carrier = '0;
    logic [DW-1:0]    jidai1 = '0;
    logic [DW-1:0]    jidai2 = '0;
    logic [7:0]       depth = '0;
    logic [1:0]       sel = '0;
    logic [DW-1:0]    am_out;
    logic [ENV_W-1:0] env_out;
    logic             out_valid;

    always #5 clk_in = ~clk_in;

    am_modulator #(
        .DW    (DW),
        .ENV_W (ENV_W)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .in_valid  (in_valid),
        .carrier   (carrier),
        .jidai1    (jidai1),
        .jidai2    (jidai2),
        .depth     (depth),
        .sel       (sel),
        .am_out    (am_out),
        .env_out   (env_out),
        .out_valid (out_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Per-cycle stimulus history; index t = inputs driven before clock edge t.
    bit h_rst [N];
    bit h_v   [N];
    int h_c   [N];
    int h_j1  [N];
    int h_j2  [N];
    int h_d   [N];
    int h_s   [N];
    bit dir_has [N];
    int dir_am  [N];
    int dir_env [N];

    int t = 0;
    int exp_ov = 0;
    int exp_am = 128;
    int exp_env = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, t, got, exp);
        end
    endtask

    function automatic int floor_div(input int num, input int den);
        int q;
        q = num / den;
        if ((num % den != 0) && (num < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int ref_env(input int j1, input int j2, input int d, input int s);
        int b;
        case (s)
            0:       b = j1 - 128;
            1:       b = j2 - 128;
            2:       b = floor_div((j1 - 128) + (j2 - 128), 2);
            default: b = 0;
        endcase
        return 256 + floor_div(b * d, 128);
    endfunction

    function automatic int ref_am(input int c, input int env);
        int y;
        y = floor_div((c - 128) * env, 512);
        return (y + 128) & 255;
    endfunction

    task automatic check_outputs();
        int k;
        bit r1, r2, r3, vk;
        k  = t - 3;
        r1 = h_rst[t-1];
        r2 = (t >= 2) ? h_rst[t-2] : 1'b1;
        r3 = (k >= 0) ? h_rst[k] : 1'b1;
        vk = (k >= 0) ? h_v[k] : 1'b0;
        if (r1) begin
            exp_ov = 0; exp_am = 128; exp_env = 0;
        end else if (vk && !r3 && !r2) begin
            exp_ov  = 1;
            exp_env = ref_env(h_j1[k], h_j2[k], h_d[k], h_s[k]);
            exp_am  = ref_am(h_c[k], exp_env);
        end else begin
            exp_ov = 0;
        end
        check_val("out_valid", 32'(out_valid), exp_ov);
        check_val("am_out", 32'(am_out), exp_am);
        check_val("env_out", 32'(env_out), exp_env);
        if (exp_ov == 1 && dir_has[k]) begin
            check_val("dir_am_out", 32'(am_out), dir_am[k]);
            check_val("dir_env_out", 32'(env_out), dir_env[k]);
        end
    endtask

    task automatic step(input bit r, input bit v, input int c, input int j1, input int j2,
                        input int d, input int s, input bit has_dir, input int dam, input int denv);
        @(negedge clk_in);
        if (t >= 1) check_outputs();
        rst      = r;
        in_valid = v;
        carrier  = 8'(c);
        jidai1   = 8'(j1);
        jidai2   = 8'(j2);
        depth    = 8'(d);
        sel      = 2'(s);
        h_rst[t] = r;  h_v[t] = v;  h_c[t] = c;  h_j1[t] = j1;
        h_j2[t] = j2;  h_d[t] = d;  h_s[t] = s;
        dir_has[t] = has_dir;  dir_am[t] = dam;  dir_env[t] = denv;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic rnd_sample(input bit r, input bit v);
        step(r, v, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), 1'b0, 0, 0);
    endtask

    initial begin
        // Reset held with in_valid toggling
        for (int i = 0; i < 5; i++) step(1'b1, 1'(i % 2), 255, 255, 255, 255, 0, 1'b0, 0, 0);

        // Directed corner samples with hand-derived results
        step(1'b0, 1'b1, 8'hFF, 8'h80, 8'h80, 0,   0, 1'b1, 8'hBF, 256);
        step(1'b0, 1'b1, 8'h00, 8'h55, 8'h22, 255, 3, 1'b1, 8'h40, 256);
        step(1'b0, 1'b1, 8'hFF, 8'hFF, 8'h12, 255, 0, 1'b1, 8'hFE, 509);
        step(1'b0, 1'b1, 8'h00, 8'h00, 8'h34, 255, 0, 1'b1, 8'h7F, 1);
        step(1'b0, 1'b1, 8'h00, 8'hC0, 8'h40, 200, 2, 1'b1, 8'h40, 256);
        idle(3);

        // Bubble pattern 1,0,1,1
        rnd_sample(1'b0, 1'b1);
        rnd_sample(1'b0, 1'b0);
        rnd_sample(1'b0, 1'b1);
        rnd_sample(1'b0, 1'b1);
        idle(4);

        // Reset with two samples in flight, then a fresh sample
        rnd_sample(1'b0, 1'b1);
        rnd_sample(1'b0, 1'b1);
        rnd_sample(1'b1, 1'b1);
        rnd_sample(1'b0, 1'b1);
        idle(5);

        // Random stream with sparse resets and bubbles
        for (int i = 0; i < 2500; i++) begin
            rnd_sample(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0));
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
